// File: rtl/fx3_host_pkg.sv
// Shared types and defaults for the FX3 GPIF-II host-side DMA model.
package fx3_host_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StRequest,
    StRead,
    StDrain
  } host_state_e;

  localparam int unsigned DefBurstWords = 4092;
  localparam int unsigned MaxThreads    = 4;

endpackage

// File: rtl/fx3_seq_checker.sv
// Read-latency pipe plus incrementing-pattern checker for the stream-in data path.
module fx3_seq_checker
  import fx3_host_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned RD_LATENCY = 2,
  parameter int unsigned CNT_W      = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rd_strobe_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CNT_W-1:0]  word_count_i,
  output logic              valid_o,
  output logic [CNT_W-1:0]  err_count_o,
  output logic [CNT_W-1:0]  first_err_word_o
);

  logic [DATA_W-1:0] expect_q;
  logic [CNT_W-1:0]  err_count_q;
  logic [CNT_W-1:0]  first_err_q;
  logic              mismatch;

  if (RD_LATENCY == 0) begin : g_no_lat
    assign valid_o = rd_strobe_i;
  end else begin : g_lat
    logic [RD_LATENCY-1:0] pipe_q;
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        pipe_q <= '0;
      end else begin
        pipe_q[0] <= rd_strobe_i;
        for (int i = 1; i < RD_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end
    assign valid_o = pipe_q[RD_LATENCY-1];
  end

  assign mismatch = valid_o && (data_i != expect_q);

  // Expected value advances on every valid word so a single bad word costs one error.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      expect_q    <= '0;
      err_count_q <= '0;
      first_err_q <= '0;
    end else begin
      if (valid_o) expect_q <= expect_q + DATA_W'(1);
      if (mismatch) begin
        if (err_count_q != '1) err_count_q <= err_count_q + CNT_W'(1);
        if (err_count_q == '0) first_err_q <= word_count_i;
      end
    end
  end

  assign err_count_o      = err_count_q;
  assign first_err_word_o = first_err_q;

endmodule

// File: rtl/fx3_dma_host_model.sv
// FX3 host model: round-robin DMA thread service, fixed-length read bursts
// from the stream-in block and pattern checking of the returned data.
module fx3_dma_host_model
  import fx3_host_pkg::*;
#(
  parameter int unsigned N_THREADS   = 2,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned BURST_WORDS = DefBurstWords,
  parameter int unsigned RD_LATENCY  = 2,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 enable,
  input  logic [N_THREADS-1:0] dma_rdy,
  input  logic                 data_available,
  input  logic [DATA_W-1:0]    data,
  output logic                 read_ready,
  output logic [1:0]           active_thread,
  output logic                 busy,
  output logic                 burst_done,
  output logic [CNT_W-1:0]     word_count,
  output logic [CNT_W-1:0]     burst_count,
  output logic [CNT_W-1:0]     err_count,
  output logic [CNT_W-1:0]     first_err_word
);

  localparam int unsigned ThreadW = $clog2(MaxThreads);
  localparam int unsigned BcW     = $clog2(BURST_WORDS + RD_LATENCY + 1);

  host_state_e        state_q, state_d;
  logic [BcW-1:0]     bcnt_q, bcnt_d;
  logic [ThreadW-1:0] thread_q, thread_d;
  logic [CNT_W-1:0]   word_count_q, burst_count_q;
  logic               rdy_sel, read_last, drain_last, data_valid;

  always_comb begin
    rdy_sel = 1'b0;
    for (int i = 0; i < N_THREADS; i++) begin
      if (thread_q == ThreadW'(i)) rdy_sel = dma_rdy[i];
    end
  end

  // bcnt counts read strobes in READ, then restarts to count drain cycles.
  assign read_last  = bcnt_q == BcW'(BURST_WORDS - 1);
  assign drain_last = bcnt_q == BcW'(RD_LATENCY);

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q  <= StIdle;
      bcnt_q   <= '0;
      thread_q <= '0;
    end else begin
      state_q  <= state_d;
      bcnt_q   <= bcnt_d;
      thread_q <= thread_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    bcnt_d   = bcnt_q;
    thread_d = thread_q;
    unique case (state_q)
      StIdle: if (enable) state_d = StWait;
      StWait: begin
        // A pending stop wins over a ready thread so no new burst starts.
        if (!enable) state_d = StIdle;
        else if (rdy_sel && data_available) state_d = StRequest;
      end
      StRequest: begin
        bcnt_d  = '0;
        state_d = StRead;
      end
      StRead: begin
        bcnt_d = bcnt_q + BcW'(1);
        if (read_last) begin
          bcnt_d  = '0;
          state_d = StDrain;
        end
      end
      StDrain: begin
        bcnt_d = bcnt_q + BcW'(1);
        if (drain_last) begin
          state_d  = StWait;
          thread_d = (thread_q == ThreadW'(N_THREADS - 1)) ? '0 : thread_q + ThreadW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    read_ready = 1'b0;
    busy       = 1'b0;
    burst_done = 1'b0;
    unique case (state_q)
      StRequest: busy = 1'b1;
      StRead: begin
        read_ready = 1'b1;
        busy       = 1'b1;
      end
      StDrain: begin
        busy       = 1'b1;
        burst_done = drain_last;
      end
      default: ;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      word_count_q  <= '0;
      burst_count_q <= '0;
    end else begin
      if (data_valid) word_count_q <= word_count_q + CNT_W'(1);
      if (burst_done) burst_count_q <= burst_count_q + CNT_W'(1);
    end
  end

  fx3_seq_checker #(
    .DATA_W     (DATA_W),
    .RD_LATENCY (RD_LATENCY),
    .CNT_W      (CNT_W)
  ) u_checker (
    .clk_i            (aclk),
    .rst_i            (areset),
    .rd_strobe_i      (read_ready),
    .data_i           (data),
    .word_count_i     (word_count_q),
    .valid_o          (data_valid),
    .err_count_o      (err_count),
    .first_err_word_o (first_err_word)
  );

  assign active_thread = 2'(thread_q);
  assign word_count    = word_count_q;
  assign burst_count   = burst_count_q;

endmodule

// File: tb/tb_fx3_dma_host_model.sv
// Scoreboard bench: two host instances (default and 3-thread/8-word/zero-latency).
module tb_fx3_dma_host_model;

  localparam int unsigned BW = 4092;

  typedef struct {
    int unsigned thread;
    int unsigned strobes;
    int unsigned words;
    int unsigned errs;
    int unsigned first_err;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;

  exp_t qa[$];
  exp_t qb[$];

  // Instance A: default parameters
  logic        a_rst, a_en, a_avail, a_corrupt;
  logic [1:0]  a_dma;
  logic [31:0] a_data, a_src;
  logic [1:0]  a_hist;
  logic        a_read_ready, a_busy, a_burst_done;
  logic [1:0]  a_active_thread;
  logic [31:0] a_word_count, a_burst_count, a_err_count, a_first_err;

  // Instance B: N_THREADS=3, BURST_WORDS=8, RD_LATENCY=0
  logic        b_rst, b_en, b_avail;
  logic [2:0]  b_dma;
  logic [31:0] b_data, b_src;
  logic        b_read_ready, b_busy, b_burst_done;
  logic [1:0]  b_active_thread;
  logic [31:0] b_word_count, b_burst_count, b_err_count, b_first_err;

  fx3_dma_host_model u_dut_a (
    .aclk           (clk),
    .areset         (a_rst),
    .enable         (a_en),
    .dma_rdy        (a_dma),
    .data_available (a_avail),
    .data           (a_data),
    .read_ready     (a_read_ready),
    .active_thread  (a_active_thread),
    .busy           (a_busy),
    .burst_done     (a_burst_done),
    .word_count     (a_word_count),
    .burst_count    (a_burst_count),
    .err_count      (a_err_count),
    .first_err_word (a_first_err)
  );

  fx3_dma_host_model #(
    .N_THREADS   (3),
    .BURST_WORDS (8),
    .RD_LATENCY  (0)
  ) u_dut_b (
    .aclk           (clk),
    .areset         (b_rst),
    .enable         (b_en),
    .dma_rdy        (b_dma),
    .data_available (b_avail),
    .data           (b_data),
    .read_ready     (b_read_ready),
    .active_thread  (b_active_thread),
    .busy           (b_busy),
    .burst_done     (b_burst_done),
    .word_count     (b_word_count),
    .burst_count    (b_burst_count),
    .err_count      (b_err_count),
    .first_err_word (b_first_err)
  );

  // Stream-in source models: word n of the pattern appears RD_LATENCY cycles after its strobe.
  always @(posedge clk) begin
    if (a_rst) begin
      a_src  <= '0;
      a_hist <= '0;
    end else begin
      a_hist <= {a_hist[0], a_read_ready};
      if (a_hist[1]) a_src <= a_src + 32'd1;
    end
  end
  assign a_data = (a_corrupt && a_src == 32'd100) ? 32'hDEAD : a_src;

  always @(posedge clk) begin
    if (b_rst) b_src <= '0;
    else if (b_read_ready) b_src <= b_src + 32'd1;
  end
  assign b_data = b_src;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_a_words(input int unsigned target, input int budget);
    int n = 0;
    while (a_word_count < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (a_word_count < target) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_a_words: word_count %0d, expected %0d", a_word_count, target);
    end
  endtask

  task automatic wait_b_words(input int unsigned target, input int budget);
    int n = 0;
    while (b_word_count < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (b_word_count < target) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_b_words: word_count %0d, expected %0d", b_word_count, target);
    end
  endtask

  // Monitors: sample just after each edge, check every burst_done against the scoreboard.
  int unsigned rr_a = 0;
  exp_t ea;
  always @(posedge clk) begin
    #1;
    if (a_rst) begin
      rr_a = 0;
    end else begin
      if (a_read_ready) rr_a++;
      if (a_burst_done) begin
        if (qa.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL a_unexpected_done: got burst_done, expected none");
        end else begin
          ea = qa.pop_front();
          check("a_thread", 64'(a_active_thread), 64'(ea.thread));
          check("a_strobes", 64'(rr_a), 64'(ea.strobes));
          check("a_words", 64'(a_word_count), 64'(ea.words));
          check("a_errs", 64'(a_err_count), 64'(ea.errs));
          check("a_first_err", 64'(a_first_err), 64'(ea.first_err));
        end
        rr_a = 0;
      end
    end
  end

  int unsigned rr_b = 0;
  logic rr_prev_b = 1'b0;
  exp_t eb;
  always @(posedge clk) begin
    #1;
    if (b_rst) begin
      rr_b = 0;
    end else begin
      if (b_read_ready) rr_b++;
      if (b_burst_done) begin
        if (qb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL b_unexpected_done: got burst_done, expected none");
        end else begin
          eb = qb.pop_front();
          check("b_thread", 64'(b_active_thread), 64'(eb.thread));
          check("b_strobes", 64'(rr_b), 64'(eb.strobes));
          check("b_words", 64'(b_word_count), 64'(eb.words));
          check("b_last_strobe_prev", 64'(rr_prev_b), 64'd1);
          check("b_rr_low_at_done", 64'(b_read_ready), 64'd0);
        end
        rr_b = 0;
      end
    end
    rr_prev_b = b_read_ready;
  end

  initial begin
    a_rst = 1'b1; a_en = 1'b0; a_avail = 1'b1; a_dma = 2'b11; a_corrupt = 1'b0;
    b_rst = 1'b1; b_en = 1'b0; b_avail = 1'b1; b_dma = 3'b111;
    repeat (3) @(negedge clk);
    check("rst_read_ready", 64'(a_read_ready), 64'd0);
    check("rst_thread", 64'(a_active_thread), 64'd0);
    check("rst_busy", 64'(a_busy), 64'd0);
    check("rst_burst_done", 64'(a_burst_done), 64'd0);
    check("rst_word_count", 64'(a_word_count), 64'd0);
    check("rst_burst_count", 64'(a_burst_count), 64'd0);
    check("rst_err_count", 64'(a_err_count), 64'd0);
    check("rst_first_err", 64'(a_first_err), 64'd0);
    a_rst = 1'b0;
    b_rst = 1'b0;

    // B: threads 0,1,2,0 with 8 strobes each
    for (int i = 0; i < 4; i++) qb.push_back('{i % 3, 8, 8 * (i + 1), 0, 0});
    b_en = 1'b1;
    wait_b_words(32, 500);
    b_en = 1'b0;
    repeat (10) @(negedge clk);
    check("b_burst_count", 64'(b_burst_count), 64'd4);
    check("b_idle_word_count", 64'(b_word_count), 64'd32);
    check("b_idle_read_ready", 64'(b_read_ready), 64'd0);
    check("b_idle_busy", 64'(b_busy), 64'd0);
    check("b_err_count", 64'(b_err_count), 64'd0);
    check("b_first_err", 64'(b_first_err), 64'd0);

    // A: four alternating bursts
    for (int i = 0; i < 4; i++) qa.push_back('{i % 2, BW, BW * (i + 1), 0, 0});
    a_en = 1'b1;
    wait_a_words(4 * BW, 20000);
    a_dma = 2'b01;
    qa.push_back('{0, BW, 5 * BW, 0, 0});
    repeat (5) @(negedge clk);
    check("a_burst_count_4", 64'(a_burst_count), 64'd4);
    check("a_words_16368", 64'(a_word_count), 64'd16368);

    // Thread 1 not ready: stall in WAIT
    wait_a_words(5 * BW, 5000);
    repeat (40) @(negedge clk);
    check("stall_read_ready", 64'(a_read_ready), 64'd0);
    check("stall_busy", 64'(a_busy), 64'd0);
    check("stall_thread", 64'(a_active_thread), 64'd1);
    check("stall_burst_count", 64'(a_burst_count), 64'd5);
    check("stall_words", 64'(a_word_count), 64'(5 * BW));
    a_dma = 2'b11;
    qa.push_back('{1, BW, 6 * BW, 0, 0});

    // Ready/available drops mid-burst are ignored; enable drop lets burst finish
    wait_a_words(5 * BW + 1000, 5000);
    a_dma = 2'b00;
    a_avail = 1'b0;
    repeat (10) @(negedge clk);
    a_dma = 2'b11;
    a_avail = 1'b1;
    wait_a_words(5 * BW + 2000, 5000);
    a_en = 1'b0;
    wait_a_words(6 * BW, 5000);
    repeat (30) @(negedge clk);
    check("stop_read_ready", 64'(a_read_ready), 64'd0);
    check("stop_busy", 64'(a_busy), 64'd0);
    check("stop_words", 64'(a_word_count), 64'(6 * BW));
    check("stop_burst_count", 64'(a_burst_count), 64'd6);

    // Reset in the middle of a burst
    a_en = 1'b1;
    wait_a_words(6 * BW + 1000, 5000);
    a_rst = 1'b1;
    @(negedge clk);
    check("mid_rst_read_ready", 64'(a_read_ready), 64'd0);
    check("mid_rst_words", 64'(a_word_count), 64'd0);
    check("mid_rst_bursts", 64'(a_burst_count), 64'd0);
    check("mid_rst_thread", 64'(a_active_thread), 64'd0);
    check("mid_rst_busy", 64'(a_busy), 64'd0);
    a_rst = 1'b0;
    a_corrupt = 1'b1;

    // Word 100 corrupted after restart: exactly one error
    qa.push_back('{0, BW, BW, 1, 100});
    qa.push_back('{1, BW, 2 * BW, 1, 100});
    wait_a_words(2 * BW, 10000);
    a_en = 1'b0;
    repeat (20) @(negedge clk);
    check("corrupt_err_count", 64'(a_err_count), 64'd1);
    check("corrupt_first_err", 64'(a_first_err), 64'd100);
    check("corrupt_bursts", 64'(a_burst_count), 64'd2);
    check("corrupt_read_ready", 64'(a_read_ready), 64'd0);
    check("qa_drained", 64'(qa.size()), 64'd0);
    check("qb_drained", 64'(qb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
